// File: rtl/carry_pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined carry-chain adder family.
package carry_pipe_adder_pkg;

    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_SEG_WIDTH = 8;

    // Number of carry-chain segments (one pipeline stage each); 0 flags an illegal split.
    function automatic int unsigned stage_count(input int unsigned width,
                                                input int unsigned seg_width);
        return (seg_width == 0) ? 0 : width / seg_width;
    endfunction

endpackage

// File: rtl/carry_pipe_seg.sv
// One carry-chain segment: SEG_WIDTH-bit add with carry-in, registered sum/carry/overflow.
module carry_pipe_seg
    import carry_pipe_adder_pkg::*;
#(
    parameter int unsigned SEG_WIDTH = DEF_SEG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [SEG_WIDTH-1:0] a,
    input  logic [SEG_WIDTH-1:0] b,
    input  logic                 ci,
    output logic [SEG_WIDTH-1:0] sum,
    output logic                 co,
    output logic                 ovf
);

    logic [SEG_WIDTH:0] full_c;
    logic               cmsb_c;

    // Plain add so synthesis maps it onto the device carry chain; recover carry into the MSB.
    always_comb begin
        full_c = {1'b0, a} + {1'b0, b} + (SEG_WIDTH + 1)'(ci);
        cmsb_c = full_c[SEG_WIDTH-1] ^ a[SEG_WIDTH-1] ^ b[SEG_WIDTH-1];
    end

    // Segment result registers, frozen while the pipe is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
            co  <= 1'b0;
            ovf <= 1'b0;
        end else if (en) begin
            sum <= full_c[SEG_WIDTH-1:0];
            co  <= full_c[SEG_WIDTH];
            ovf <= cmsb_c ^ full_c[SEG_WIDTH];
        end
    end

endmodule

// File: rtl/carry_pipe_adder.sv
// Pipelined adder/subtractor: one carry segment per stage, skewed inputs, deskewed outputs.
module carry_pipe_adder
    import carry_pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned SEG_WIDTH = DEF_SEG_WIDTH,
    parameter int unsigned STAGES    = stage_count(WIDTH, SEG_WIDTH)
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             BI,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Y,
    output logic             CO,
    output logic             V,
    output logic             out_valid,
    input  logic             out_ready
);

    // Reject segmentations that do not tile the operand exactly.
    if (SEG_WIDTH == 0) begin : g_bad_seg
        $error("carry_pipe_adder: SEG_WIDTH must be at least 1");
    end else if ((WIDTH % SEG_WIDTH) != 0) begin : g_bad_split
        $error("carry_pipe_adder: WIDTH must be a multiple of SEG_WIDTH");
    end else if ((STAGES == 0) || (STAGES != WIDTH / SEG_WIDTH)) begin : g_bad_stages
        $error("carry_pipe_adder: STAGES is derived and must not be overridden");
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] seg_co;
    logic [STAGES-1:0] seg_ovf;
    logic              unused_ovf;

    // Whole pipe advances together unless a finished result is waiting on the consumer.
    always_comb begin
        en    = !out_valid || out_ready;
        b_eff = BI ? ~B : B;
    end

    assign in_ready   = en;
    assign out_valid  = vld[STAGES-1];
    assign CO         = seg_co[STAGES-1];
    assign V          = seg_ovf[STAGES-1];
    assign unused_ovf = ^seg_ovf;

    // Valid bit per stage; bubbles ride along as zeros.
    always_ff @(posedge C) begin
        if (R) begin
            vld <= '0;
        end else if (en) begin
            vld <= STAGES'({vld, in_valid});
        end
    end

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        localparam int unsigned LSB    = k * SEG_WIDTH;
        localparam int unsigned DESKEW = STAGES - 1 - k;

        logic [SEG_WIDTH-1:0] a_sl;
        logic [SEG_WIDTH-1:0] b_sl;
        logic [SEG_WIDTH-1:0] sum_q;
        logic                 cin;

        if (k == 0) begin : g_first
            assign a_sl = A[LSB +: SEG_WIDTH];
            assign b_sl = b_eff[LSB +: SEG_WIDTH];
            assign cin  = CI;
        end else begin : g_skew
            localparam int unsigned SKEW_W = k * SEG_WIDTH;
            logic [SKEW_W-1:0] a_sr;
            logic [SKEW_W-1:0] b_sr;

            // Delay this operand slice k cycles so it meets the carry from stage k-1.
            always_ff @(posedge C) begin
                if (R) begin
                    a_sr <= '0;
                    b_sr <= '0;
                end else if (en) begin
                    a_sr <= SKEW_W'({a_sr, A[LSB +: SEG_WIDTH]});
                    b_sr <= SKEW_W'({b_sr, b_eff[LSB +: SEG_WIDTH]});
                end
            end

            assign a_sl = a_sr[SKEW_W-1 -: SEG_WIDTH];
            assign b_sl = b_sr[SKEW_W-1 -: SEG_WIDTH];
            assign cin  = seg_co[k-1];
        end

        carry_pipe_seg #(
            .SEG_WIDTH (SEG_WIDTH)
        ) u_seg (
            .clk (C),
            .rst (R),
            .en  (en),
            .a   (a_sl),
            .b   (b_sl),
            .ci  (cin),
            .sum (sum_q),
            .co  (seg_co[k]),
            .ovf (seg_ovf[k])
        );

        if (DESKEW == 0) begin : g_last
            assign Y[LSB +: SEG_WIDTH] = sum_q;
        end else begin : g_deskew
            localparam int unsigned DSK_W = DESKEW * SEG_WIDTH;
            logic [DSK_W-1:0] y_sr;

            // Hold early result slices until the top segment has finished.
            always_ff @(posedge C) begin
                if (R) begin
                    y_sr <= '0;
                end else if (en) begin
                    y_sr <= DSK_W'({y_sr, sum_q});
                end
            end

            assign Y[LSB +: SEG_WIDTH] = y_sr[DSK_W-1 -: SEG_WIDTH];
        end
    end

endmodule

// File: tb/tb_carry_pipe_adder.sv
// Directed and model-backed checks for carry_pipe_adder (32/8 and 8/8 instances).
module tb_carry_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] a, b, y;
    logic        ci, bi, in_valid, in_ready, co, v, out_valid, out_ready;
    logic [7:0]  a8, b8, y8;
    logic        ci8, bi8, in_valid8, in_ready8, co8, v8, out_valid8, out_ready8;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected values are packed {V, CO, Y}.
    localparam logic [31:0] BB_A [6] = '{32'h00000005, 32'h7FFFFFFF, 32'h80000000,
                                         32'h80000000, 32'h00FF00FF, 32'h12345678};
    localparam logic [31:0] BB_B [6] = '{32'h00000007, 32'h00000001, 32'h80000000,
                                         32'h00000001, 32'h0000FF00, 32'h12345678};
    localparam logic [5:0]  BB_BI = 6'b101001;
    localparam logic [5:0]  BB_CI = 6'b011001;
    localparam logic [33:0] BB_E [6] = '{34'h0_FFFFFFFE, 34'h2_80000000, 34'h3_00000000,
                                         34'h3_7FFFFFFF, 34'h0_01000000, 34'h0_FFFFFFFF};

    localparam logic [31:0] ST_A [5] = '{32'h00000001, 32'h0000FFFF, 32'hFFFF0000,
                                         32'h40000000, 32'hAAAAAAAA};
    localparam logic [31:0] ST_B [5] = '{32'h00000002, 32'h00000001, 32'h00010000,
                                         32'h40000000, 32'h55555555};
    localparam logic [33:0] ST_E [5] = '{34'h0_00000003, 34'h0_00010000, 34'h1_00000000,
                                         34'h2_80000000, 34'h0_FFFFFFFF};

    carry_pipe_adder #(.WIDTH(32), .SEG_WIDTH(8)) u_dut (
        .C(clk), .R(rst), .A(a), .B(b), .CI(ci), .BI(bi),
        .in_valid(in_valid), .in_ready(in_ready), .Y(y), .CO(co), .V(v),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    carry_pipe_adder #(.WIDTH(8), .SEG_WIDTH(8)) u_dut8 (
        .C(clk), .R(rst), .A(a8), .B(b8), .CI(ci8), .BI(bi8),
        .in_valid(in_valid8), .in_ready(in_ready8), .Y(y8), .CO(co8), .V(v8),
        .out_valid(out_valid8), .out_ready(out_ready8)
    );

    function automatic logic [33:0] model(input logic [31:0] fa, input logic [31:0] fb,
                                          input logic fbi, input logic fci);
        logic [31:0] bb;
        logic [32:0] s;
        logic        c31;
        bb  = fbi ? ~fb : fb;
        s   = {1'b0, fa} + {1'b0, bb} + 33'(fci);
        c31 = s[31] ^ fa[31] ^ bb[31];
        return {c31 ^ s[32], s[32], s[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; bi = 1'b0;
    endtask

    task automatic drive(input logic [31:0] ta, input logic [31:0] tb,
                         input logic tbi, input logic tci);
        a = ta; b = tb; bi = tbi; ci = tci; in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b0; out_ready8 = 1'b0; idle();
        tick(); tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if ({v, co, y} !== 34'h0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", {v, co, y}); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin n_fail++; $display("FAIL reset_dut8: got valid %b ready %b expected 0/1", out_valid8, in_ready8); end
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        drive(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        tick();
        idle();
        for (int t = 1; t <= 5; t++) begin
            if (t > 1) tick();
            n_cmp++; if (out_valid !== (t == 4)) begin n_fail++; $display("FAIL latency_valid[t=%0d]: got %b expected %b", t, out_valid, (t == 4)); end
            if (t == 4) begin
                n_cmp++; if ({v, co, y} !== 34'h1_00000000) begin n_fail++; $display("FAIL latency_result: got %h expected 100000000", {v, co, y}); end
            end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            int j;
            if (c < 6) drive(BB_A[c], BB_B[c], BB_BI[c], BB_CI[c]);
            else idle();
            tick();
            j = c - 3;
            if (j >= 0 && j < 6) begin
                n_cmp++; if (out_valid !== 1'b1 || {v, co, y} !== BB_E[j]) begin n_fail++; $display("FAIL b2b[%0d]: got valid %b %h expected 1 %h", j, out_valid, {v, co, y}, BB_E[j]); end
            end else begin
                n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle[c=%0d]: got valid %b expected 0", c, out_valid); end
            end
        end
        idle();
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(ST_A[i], ST_B[i], 1'b0, 1'b0);
            tick();
        end
        n_cmp++; if (out_valid !== 1'b1 || {v, co, y} !== ST_E[0]) begin n_fail++; $display("FAIL stall_first: got valid %b %h expected 1 %h", out_valid, {v, co, y}, ST_E[0]); end
        drive(ST_A[4], ST_B[4], 1'b0, 1'b0);
        out_ready = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_drop: got %b expected 0", in_ready); end
        for (int s = 0; s < 3; s++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b1 || {v, co, y} !== ST_E[0] || in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_hold[%0d]: got valid %b %h ready %b expected 1 %h 0", s, out_valid, {v, co, y}, in_ready, ST_E[0]); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b expected 1", in_ready); end
        for (int j = 1; j < 5; j++) begin
            tick();
            idle();
            n_cmp++; if (out_valid !== 1'b1 || {v, co, y} !== ST_E[j]) begin n_fail++; $display("FAIL stall_drain[%0d]: got valid %b %h expected 1 %h", j, out_valid, {v, co, y}, ST_E[j]); end
        end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_empty: got valid %b expected 0", out_valid); end
    endtask

    task automatic test_random();
        logic [33:0] expq[$];
        logic [33:0] held;
        logic [33:0] e;
        logic        stalled;
        int          sent  = 0;
        int          recvd = 0;
        for (int cyc = 0; cyc < 400 && recvd < 16; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 16) drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else idle();
            #1;
            stalled = out_valid && !out_ready;
            held    = {v, co, y};
            if (out_valid && out_ready) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra: got %h expected no result", {v, co, y});
                end else begin
                    e = expq.pop_front();
                    if ({v, co, y} !== e) begin n_fail++; $display("FAIL rand_result[%0d]: got %h expected %h", recvd, {v, co, y}, e); end
                end
                recvd++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(a, b, bi, ci));
                sent++;
            end
            tick();
            if (stalled) begin
                n_cmp++; if (out_valid !== 1'b1 || {v, co, y} !== held) begin n_fail++; $display("FAIL rand_stall_stable: got valid %b %h expected 1 %h", out_valid, {v, co, y}, held); end
            end
        end
        n_cmp++; if (recvd != 16) begin n_fail++; $display("FAIL rand_count: got %0d expected 16", recvd); end
        idle();
        out_ready = 1'b1;
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        drive(32'h11111111, 32'h22222222, 1'b0, 1'b0); tick();
        drive(32'h33333333, 32'h44444444, 1'b0, 1'b1); tick();
        drive(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 1'b0); tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || {v, co, y} !== 34'h0) begin n_fail++; $display("FAIL flush_cleared: got valid %b %h expected 0 0", out_valid, {v, co, y}); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
        drive(32'h00000010, 32'h00000020, 1'b0, 1'b0);
        tick();
        idle();
        for (int t = 1; t <= 6; t++) begin
            if (t > 1) tick();
            n_cmp++; if (out_valid !== (t == 4)) begin n_fail++; $display("FAIL flush_valid[t=%0d]: got %b expected %b", t, out_valid, (t == 4)); end
            if (t == 4) begin
                n_cmp++; if ({v, co, y} !== 34'h0_00000030) begin n_fail++; $display("FAIL flush_new_result: got %h expected 000000030", {v, co, y}); end
            end
        end
    endtask

    task automatic test_single_stage();
        out_ready8 = 1'b1;
        a8 = 8'h80; b8 = 8'h80; bi8 = 1'b0; ci8 = 1'b0; in_valid8 = 1'b1;
        #1;
        n_cmp++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin n_fail++; $display("FAIL s1_pre: got ready %b valid %b expected 1 0", in_ready8, out_valid8); end
        tick();
        n_cmp++; if (out_valid8 !== 1'b1 || {v8, co8, y8} !== 10'h300) begin n_fail++; $display("FAIL s1_80p80: got valid %b %h expected 1 300", out_valid8, {v8, co8, y8}); end
        a8 = 8'h7F; b8 = 8'h01;
        tick();
        n_cmp++; if (out_valid8 !== 1'b1 || {v8, co8, y8} !== 10'h280) begin n_fail++; $display("FAIL s1_7fp01: got valid %b %h expected 1 280", out_valid8, {v8, co8, y8}); end
        a8 = 8'h10; b8 = 8'h20; bi8 = 1'b1; ci8 = 1'b1;
        tick();
        n_cmp++; if (out_valid8 !== 1'b1 || {v8, co8, y8} !== 10'h0F0) begin n_fail++; $display("FAIL s1_10m20: got valid %b %h expected 1 0f0", out_valid8, {v8, co8, y8}); end
        in_valid8 = 1'b0;
        tick();
        n_cmp++; if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL s1_idle: got valid %b expected 0", out_valid8); end
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b0; idle();
        a8 = '0; b8 = '0; ci8 = 1'b0; bi8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_stall();
        test_random();
        test_flush();
        test_single_stage();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/carry_pipe_adder.md
CARRY_PIPE_ADDER -- requirements
Module: carry_pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning total operand and result width in bits.
REQ-002 The block SHALL have parameter SEG_WIDTH, default 8, meaning bits per carry-chain segment, one segment per pipeline stage.
REQ-003 The block SHALL have parameter STAGES, default WIDTH/SEG_WIDTH, meaning derived pipeline depth; it is not to be overridden.
REQ-004 The block SHALL have port C, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port R, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port A, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port B, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port CI, input, 1 bit: carry-in.
REQ-009 The block SHALL have port BI, input, 1 bit: invert B (subtract when CI=1).
REQ-010 The block SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-011 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-012 The block SHALL have port Y, output, WIDTH bits: sum A + (BI ? ~B : B) + CI.
REQ-013 The block SHALL have port CO, output, 1 bit: carry-out of the MSB.
REQ-014 The block SHALL have port V, output, 1 bit: signed overflow, equal to the carry into the MSB XOR CO.
REQ-015 The block SHALL have port out_valid, output, 1 bit: Y, CO and V are valid.
REQ-016 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-017 Elaboration SHALL fail if WIDTH is not a multiple of SEG_WIDTH or if SEG_WIDTH < 1.
REQ-018 Stage k (0..STAGES-1) SHALL add operand bits [k*SEG_WIDTH +: SEG_WIDTH] with the carry registered from stage k-1; stage 0 uses CI.
REQ-019 Operand slices for stage k SHALL be delayed k cycles (triangular input skew), and result slice k SHALL be delayed STAGES-1-k cycles (output deskew), so all bits of one result appear together.
REQ-020 Each stage SHALL carry a valid bit; a transfer in occurs when in_valid && in_ready, and a transfer out occurs when out_valid && out_ready.
REQ-021 Global advance enable en SHALL be (!out_valid || out_ready); in_ready SHALL equal en; all pipeline registers, including valid bits, SHALL update only when en=1.
REQ-022 With out_ready held at 1, latency SHALL be exactly STAGES cycles from the transfer in to out_valid, with throughput of one result per cycle.
REQ-023 When the output is stalled (out_valid=1, out_ready=0), Y, CO, V and out_valid SHALL hold stable and no operand SHALL be accepted.
REQ-024 Bubbles (in_valid=0 while en=1) SHALL propagate as invalid stages; results SHALL leave in acceptance order, none lost or duplicated.
REQ-025 BI and CI SHALL be sampled with the operands and travel with them; no cross-talk between in-flight operations.
REQ-026 For STAGES=1 the block SHALL degenerate to one registered adder with latency 1.

Reset
REQ-027 While R=1 at a clock edge, all valid bits, Y, CO, V and inter-stage carries SHALL clear to 0; in_ready SHALL read 1 in the first cycle after reset.
REQ-028 Reset SHALL take priority over en; operations in flight at reset SHALL be discarded, and no out_valid SHALL be asserted for them.

Structure
REQ-029 A shared package SHALL hold default WIDTH/SEG_WIDTH constants and a stage-count function used by this block and the arithmetic techmaps.
REQ-030 One sub-module, carry_pipe_seg, SHALL implement one segment: a SEG_WIDTH-bit add with carry-in and carry-out plus its registers, and SHALL map onto the device carry chain.

Verification
REQ-031 A=0xFFFFFFFF, B=1, BI=0, CI=0, out_ready=1 -> 4 cycles later Y=0x00000000, CO=1, V=0.
REQ-032 A=5, B=7, BI=1, CI=1 -> Y=0xFFFFFFFE, CO=0, V=0; A=0x7FFFFFFF, B=1, BI=0, CI=0 -> Y=0x80000000, V=1, CO=0.
REQ-033 Feed 16 random back-to-back operands while out_ready toggles pseudo-randomly -> 16 results in order matching the reference model; outputs stable during every stall cycle.
REQ-034 Hold out_ready=0 after the first result -> in_ready drops in the same cycle, and once released all results drain in order.
REQ-035 Assert R for 1 cycle with 3 operations in flight -> out_valid=0 and all outputs 0 on the next cycle; none of the 3 results ever appears; a new operand is accepted immediately.
REQ-036 Instance with WIDTH=8, SEG_WIDTH=8 -> latency 1; 0x80+0x80 gives Y=0x00, CO=1, V=1.
